// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard definitions.
// Prefix codes, modifier codes, FSM states, event record.
package ps2_pkg;

  localparam logic [7:0] CODE_EXT    = 8'hE0;
  localparam logic [7:0] CODE_BRK    = 8'hF0;
  localparam logic [7:0] CODE_LSHIFT = 8'h12;
  localparam logic [7:0] CODE_RSHIFT = 8'h59;
  localparam logic [7:0] CODE_CAPS   = 8'h58;
  localparam logic [7:0] CODE_BAT    = 8'hAA;
  localparam logic [7:0] CODE_RESEND = 8'hFE;
  localparam logic [7:0] CODE_ERR    = 8'hFF;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_EXT,
    PF_BRK,
    PF_EXTBRK
  } pfx_state_t;

  typedef struct packed {
    logic [7:0] ascii;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ev_t;

endpackage

// File: rtl/ps2_keyboard_ascii_map.sv
// Set-2 scancode to ASCII ROM.
// Letters follow shift^caps; digits and punctuation follow shift.
module ps2_ascii_map
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);

  logic [7:0] lo;
  logic [7:0] hi;
  logic       letter;
  logic       upper;

  always_comb begin
    lo = 8'h00;
    hi = 8'h00;
    unique case (code)
      8'h1C: lo = "a";
      8'h32: lo = "b";
      8'h21: lo = "c";
      8'h23: lo = "d";
      8'h24: lo = "e";
      8'h2B: lo = "f";
      8'h34: lo = "g";
      8'h33: lo = "h";
      8'h43: lo = "i";
      8'h3B: lo = "j";
      8'h42: lo = "k";
      8'h4B: lo = "l";
      8'h3A: lo = "m";
      8'h31: lo = "n";
      8'h44: lo = "o";
      8'h4D: lo = "p";
      8'h15: lo = "q";
      8'h2D: lo = "r";
      8'h1B: lo = "s";
      8'h2C: lo = "t";
      8'h3C: lo = "u";
      8'h2A: lo = "v";
      8'h1D: lo = "w";
      8'h22: lo = "x";
      8'h35: lo = "y";
      8'h1A: lo = "z";
      8'h16: begin lo = "1"; hi = "!"; end
      8'h1E: begin lo = "2"; hi = "@"; end
      8'h26: begin lo = "3"; hi = "#"; end
      8'h25: begin lo = "4"; hi = "$"; end
      8'h2E: begin lo = "5"; hi = "%"; end
      8'h36: begin lo = "6"; hi = "^"; end
      8'h3D: begin lo = "7"; hi = "&"; end
      8'h3E: begin lo = "8"; hi = "*"; end
      8'h46: begin lo = "9"; hi = "("; end
      8'h45: begin lo = "0"; hi = ")"; end
      8'h0E: begin lo = 8'h60; hi = "~"; end
      8'h4E: begin lo = "-"; hi = "_"; end
      8'h55: begin lo = "="; hi = "+"; end
      8'h54: begin lo = "["; hi = "{"; end
      8'h5B: begin lo = "]"; hi = "}"; end
      8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
      8'h4C: begin lo = ";"; hi = ":"; end
      8'h52: begin lo = 8'h27; hi = 8'h22; end
      8'h41: begin lo = ","; hi = "<"; end
      8'h49: begin lo = "."; hi = ">"; end
      8'h4A: begin lo = "/"; hi = "?"; end
      8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
      8'h66: begin lo = 8'h08; hi = 8'h08; end
      8'h29: begin lo = 8'h20; hi = 8'h20; end
      8'h76: begin lo = 8'h1B; hi = 8'h1B; end
      default: begin lo = 8'h00; hi = 8'h00; end
    endcase
  end

  // Letter rows only store lower case; upper is a fixed offset.
  assign letter = (lo >= "a") && (lo <= "z");
  assign upper  = letter ? (shift ^ caps) : shift;
  assign ascii  = !upper ? lo
                : letter ? (lo - 8'h20)
                : hi;

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: sync, framing, prefix FSM,
// modifier tracking, ASCII lookup and show-ahead event FIFO.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int EMIT_BREAK     = 1
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [7:0] ev_ascii,
  output logic       err_frame,
  output logic       err_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sq;
  logic [SYNC_STAGES-1:0] dat_sq;
  logic                   clk_d;
  logic                   clk_s;
  logic                   dat_s;
  logic                   fall;

  assign clk_s = clk_sq[SYNC_STAGES-1];
  assign dat_s = dat_sq[SYNC_STAGES-1];
  assign fall  = clk_d & ~clk_s;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      clk_sq <= '1;
      dat_sq <= '1;
      clk_d  <= 1'b1;
    end else begin
      clk_sq <= {clk_sq[SYNC_STAGES-2:0], ps2_clk};
      dat_sq <= {dat_sq[SYNC_STAGES-2:0], ps2_data};
      clk_d  <= clk_s;
    end
  end

  logic [3:0]    bit_cnt;
  logic [10:0]   frame;
  logic          frame_done;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          frame_bad;
  logic          byte_ok;
  logic [7:0]    rx_byte;

  assign tmo_hit   = (bit_cnt != 4'd0)
                   && (tmo == TW'(TIMEOUT_CYCLES));
  assign frame_bad = frame[0] | ~frame[10]
                   | ~(^frame[9:1]);
  assign byte_ok   = frame_done & ~frame_bad;
  assign rx_byte   = frame[8:1];

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      bit_cnt    <= 4'd0;
      frame      <= '0;
      frame_done <= 1'b0;
      tmo        <= '0;
      err_frame  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      err_frame  <= (frame_done & frame_bad) | tmo_hit;
      if (fall || bit_cnt == 4'd0 || tmo_hit)
        tmo <= '0;
      else
        tmo <= tmo + TW'(1);
      if (fall) begin
        frame <= {dat_s, frame[10:1]};
        if (bit_cnt == 4'd10) begin
          bit_cnt    <= 4'd0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else if (tmo_hit) begin
        bit_cnt <= 4'd0;
      end
    end
  end

  pfx_state_t st;
  pfx_state_t st_nx;
  logic       emit;
  logic       e_ext;
  logic       e_brk;
  logic       ignorable;

  assign ignorable = (rx_byte == CODE_BAT)
                   | (rx_byte == CODE_RESEND)
                   | (rx_byte == CODE_ERR);

  always_ff @(posedge clk) begin
    if (!clr_n) st <= PF_IDLE;
    else        st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    emit  = 1'b0;
    e_ext = (st == PF_EXT) | (st == PF_EXTBRK);
    e_brk = (st == PF_BRK) | (st == PF_EXTBRK);
    if (byte_ok) begin
      unique case (1'b1)
        (st == PF_IDLE && rx_byte == CODE_EXT):
          st_nx = PF_EXT;
        (st == PF_IDLE && rx_byte == CODE_BRK):
          st_nx = PF_BRK;
        (st == PF_EXT && rx_byte == CODE_BRK):
          st_nx = PF_EXTBRK;
        (st == PF_IDLE && ignorable):
          st_nx = PF_IDLE;
        default: begin
          emit  = 1'b1;
          st_nx = PF_IDLE;
        end
      endcase
    end
  end

  logic       shift;
  logic       caps;
  logic [7:0] map_ascii;
  logic       is_shift;

  assign is_shift = (rx_byte == CODE_LSHIFT)
                  | (rx_byte == CODE_RSHIFT);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      shift <= 1'b0;
      caps  <= 1'b0;
    end else if (emit && !e_ext) begin
      if (is_shift)
        shift <= ~e_brk;
      if (rx_byte == CODE_CAPS && !e_brk)
        caps <= ~caps;
    end
  end

  ps2_ascii_map u_map (
    .code  (rx_byte),
    .shift (shift),
    .caps  (caps),
    .ascii (map_ascii)
  );

  ev_t  ev_new;
  ev_t  head;
  logic push;

  always_comb begin
    ev_new       = '0;
    ev_new.code  = rx_byte;
    ev_new.ext   = e_ext;
    ev_new.brk   = e_brk;
    ev_new.ascii = (e_ext | e_brk) ? 8'h00 : map_ascii;
  end

  assign push = emit & ((EMIT_BREAK != 0) | ~e_brk);

  ev_t         mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW])
               && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = ~empty & ev_ready;
  assign wr    = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wptr         <= '0;
      rptr         <= '0;
      err_overflow <= 1'b0;
    end else begin
      err_overflow <= push & full & ~pop;
      if (wr) begin
        mem[wptr[AW-1:0]] <= ev_new;
        wptr              <= wptr + 1'b1;
      end
      if (pop)
        rptr <= rptr + 1'b1;
    end
  end

  assign head     = mem[rptr[AW-1:0]];
  assign ev_valid = ~empty;
  assign ev_code  = head.code;
  assign ev_ext   = head.ext;
  assign ev_break = head.brk;
  assign ev_ascii = head.ascii;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard.
// Bit-bangs PS/2 frames and checks queued events.
module tb_ps2_keyboard;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ev_ready = 1'b1;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [7:0] ev_ascii;
  logic       err_frame;
  logic       err_overflow;

  int pass = 0;
  int total = 0;
  int n_ferr = 0;
  int n_ovf = 0;
  logic [17:0] q[$];

  ps2_keyboard #(
    .SYNC_STAGES    (2),
    .FIFO_DEPTH     (8),
    .TIMEOUT_CYCLES (300),
    .EMIT_BREAK     (1)
  ) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_code      (ev_code),
    .ev_ext       (ev_ext),
    .ev_break     (ev_break),
    .ev_ascii     (ev_ascii),
    .err_frame    (err_frame),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ev_valid && ev_ready)
      q.push_back({ev_ascii, ev_break, ev_ext, ev_code});
    if (err_frame) n_ferr++;
    if (err_overflow) n_ovf++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] frame_of(
    input logic [7:0] d, input logic flip);
    return {1'b1, ~(^d) ^ flip, d, 1'b0};
  endfunction

  task automatic send(input logic [7:0] d);
    logic [10:0] f;
    f = frame_of(d, 1'b0);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    cyc(4);
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    cyc(3);
    total++;
    if (ev_valid !== 1'b0)
      $display("FAIL reset_valid got %b want 0", ev_valid);
    else pass++;
    total++;
    if ({err_frame, err_overflow} !== 2'b00)
      $display("FAIL reset_err got %b want 00",
               {err_frame, err_overflow});
    else pass++;
    total++;
    if ({ev_ascii, ev_break, ev_ext, ev_code} !== 18'h0)
      $display("FAIL reset_fields got %h want 0",
               {ev_ascii, ev_break, ev_ext, ev_code});
    else pass++;
    clr_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_latency;
    logic [10:0] f;
    q.delete();
    f = frame_of(8'h1C, 1'b0);
    for (int i = 0; i < 10; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    // two synchroniser cycles, then detect, then write
    cyc(3);
    total++;
    if (ev_valid !== 1'b0)
      $display("FAIL lat_early got %b want 0", ev_valid);
    else pass++;
    cyc(1);
    total++;
    if (ev_valid !== 1'b1)
      $display("FAIL lat_valid got %b want 1", ev_valid);
    else pass++;
    total++;
    if ({ev_ascii, ev_code} !== 16'h611C)
      $display("FAIL lat_head got %h want 611c",
               {ev_ascii, ev_code});
    else pass++;
    cyc(4);
    ps2_clk = 1'b1;
    cyc(HALF);
    total++;
    if (q.size() != 1 || q[0] !== {8'h61, 2'b00, 8'h1C})
      $display("FAIL lat_event got n=%0d %h want 1 %h",
               q.size(), q.size() ? q[0] : 18'h0,
               {8'h61, 2'b00, 8'h1C});
    else pass++;
  endtask

  task automatic test_shift;
    logic [17:0] exp [5];
    exp = '{{8'h00, 2'b00, 8'h12},
            {8'h41, 2'b00, 8'h1C},
            {8'h00, 2'b10, 8'h1C},
            {8'h00, 2'b10, 8'h12},
            {8'h61, 2'b00, 8'h1C}};
    q.delete();
    send(8'h12); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'hF0); send(8'h12);
    send(8'h1C);
    total++;
    if (q.size() != 5)
      $display("FAIL shift_count got %0d want 5", q.size());
    else pass++;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (q[i] !== exp[i])
        $display("FAIL shift_ev%0d got %h want %h",
                 i, q[i], exp[i]);
      else pass++;
    end
  endtask

  task automatic test_ext;
    q.delete();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    total++;
    if (q.size() != 2)
      $display("FAIL ext_count got %0d want 2", q.size());
    else pass++;
    total++;
    if (q[0] !== {8'h00, 2'b01, 8'h75})
      $display("FAIL ext_make got %h want %h",
               q[0], {8'h00, 2'b01, 8'h75});
    else pass++;
    total++;
    if (q[1] !== {8'h00, 2'b11, 8'h75})
      $display("FAIL ext_break got %h want %h",
               q[1], {8'h00, 2'b11, 8'h75});
    else pass++;
  endtask

  task automatic test_errors;
    int base;
    logic [10:0] f;
    q.delete();
    base = n_ferr;
    f = frame_of(8'h1C, 1'b1);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    cyc(6);
    total++;
    if (n_ferr - base != 1)
      $display("FAIL parity_err got %0d want 1",
               n_ferr - base);
    else pass++;
    f = frame_of(8'h2E, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    cyc(400);
    total++;
    if (n_ferr - base != 2)
      $display("FAIL timeout_err got %0d want 2",
               n_ferr - base);
    else pass++;
    total++;
    if (q.size() != 0)
      $display("FAIL err_noev got %0d want 0", q.size());
    else pass++;
    send(8'h2E);
    total++;
    if (q.size() != 1 || q[0] !== {8'h35, 2'b00, 8'h2E})
      $display("FAIL err_recover got n=%0d %h want %h",
               q.size(), q.size() ? q[0] : 18'h0,
               {8'h35, 2'b00, 8'h2E});
    else pass++;
  endtask

  task automatic test_overflow;
    logic [7:0] codes [9];
    logic [7:0] asc [9];
    int base;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
              8'h35, 8'h3C, 8'h43, 8'h44};
    asc   = '{8'h71, 8'h77, 8'h65, 8'h72, 8'h74,
              8'h79, 8'h75, 8'h69, 8'h6F};
    q.delete();
    base = n_ovf;
    ev_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(codes[i]);
    total++;
    if (n_ovf - base != 1)
      $display("FAIL ovf_pulse got %0d want 1", n_ovf - base);
    else pass++;
    total++;
    if (ev_valid !== 1'b1 || ev_code !== 8'h15)
      $display("FAIL ovf_head got %b/%h want 1/15",
               ev_valid, ev_code);
    else pass++;
    ev_ready = 1'b1;
    cyc(20);
    total++;
    if (q.size() != 8)
      $display("FAIL ovf_drain got %0d want 8", q.size());
    else pass++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (q[i] !== {asc[i], 2'b00, codes[i]})
        $display("FAIL ovf_ev%0d got %h want %h",
                 i, q[i], {asc[i], 2'b00, codes[i]});
      else pass++;
    end
  endtask

  task automatic test_reset_midframe;
    int base;
    logic [10:0] f;
    q.delete();
    base = n_ferr;
    f = frame_of(8'h16, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(f[i]);
    clr_n = 1'b0;
    cyc(2);
    clr_n = 1'b1;
    cyc(2);
    send(8'h16);
    total++;
    if (n_ferr != base)
      $display("FAIL rst_noerr got %0d want 0", n_ferr - base);
    else pass++;
    total++;
    if (q.size() != 1 || q[0] !== {8'h31, 2'b00, 8'h16})
      $display("FAIL rst_event got n=%0d %h want %h",
               q.size(), q.size() ? q[0] : 18'h0,
               {8'h31, 2'b00, 8'h16});
    else pass++;
  endtask

  task automatic test_caps;
    logic [17:0] exp [7];
    exp = '{{8'h00, 2'b00, 8'h58},
            {8'h00, 2'b10, 8'h58},
            {8'h41, 2'b00, 8'h1C},
            {8'h00, 2'b00, 8'h12},
            {8'h61, 2'b00, 8'h1C},
            {8'h21, 2'b00, 8'h16},
            {8'h00, 2'b10, 8'h12}};
    q.delete();
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'h1C); send(8'h12); send(8'h1C);
    send(8'h16); send(8'hF0); send(8'h12);
    total++;
    if (q.size() != 7)
      $display("FAIL caps_count got %0d want 7", q.size());
    else pass++;
    for (int i = 0; i < 7; i++) begin
      total++;
      if (q[i] !== exp[i])
        $display("FAIL caps_ev%0d got %h want %h",
                 i, q[i], exp[i]);
      else pass++;
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_shift;
    test_ext;
    test_errors;
    test_overflow;
    test_reset_midframe;
    test_caps;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
